// File: rtl/inst_cmd_fetch_if.sv
// Bundle of the instruction-memory read ports and the two downstream handshakes
// (decoded header and operand beats) of the command fetcher.
interface inst_cmd_fetch_if #(
  parameter int OPW = 8
);
  logic [31:0]    inst_addr1;
  logic [31:0]    inst_rd0;
  logic [31:0]    inst_addr2;
  logic [31:0]    inst_rd1;
  logic [31:0]    inst_rd2;
  logic [31:0]    inst_rd3;
  logic [31:0]    inst_rd4;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_opcode;
  logic [OPW-1:0] cmd_imm;
  logic [OPW-1:0] cmd_nops;

  logic           op_valid;
  logic           op_ready;
  logic [31:0]    op_data0;
  logic [31:0]    op_data1;
  logic [31:0]    op_data2;
  logic [31:0]    op_data3;
  logic [2:0]     op_cnt;
  logic           op_last;

  modport master (
    output inst_addr1, inst_addr2,
    input  inst_rd0, inst_rd1, inst_rd2, inst_rd3, inst_rd4,
    output cmd_valid, cmd_opcode, cmd_imm, cmd_nops,
    input  cmd_ready,
    output op_valid, op_data0, op_data1, op_data2, op_data3, op_cnt, op_last,
    input  op_ready
  );

  modport slave (
    input  inst_addr1, inst_addr2,
    output inst_rd0, inst_rd1, inst_rd2, inst_rd3, inst_rd4,
    input  cmd_valid, cmd_opcode, cmd_imm, cmd_nops,
    output cmd_ready,
    input  op_valid, op_data0, op_data1, op_data2, op_data3, op_cnt, op_last,
    output op_ready
  );
endinterface

// File: rtl/inst_cmd_fetch.sv
// Walks the asynchronous instruction BRAM from base_addr to end_addr and emits
// one decoded header per command followed by operand beats of up to 4 words.
module inst_cmd_fetch #(
  parameter int MEM_DEPTH = 64,
  parameter int OPW       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [31:0]           end_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  inst_cmd_fetch_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CMD,
    S_OPS_F,
    S_OPS_S
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [OPW-1:0] rem_q, rem_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic [OPW-1:0] imm_q, imm_d;
  logic [OPW-1:0] nops_q, nops_d;
  logic [31:0]    data_q [4];
  logic [31:0]    data_d [4];
  logic [2:0]     cnt_q, cnt_d;
  logic           last_q, last_d;

  logic           hdr_ext;
  logic [OPW-1:0] hdr_n;
  logic [31:0]    hdr_bound;
  logic [2:0]     beat_cnt;
  logic [31:0]    win [4];
  logic           unused_hdr_bits;

  assign hdr_ext         = bus.inst_rd0[31];
  assign hdr_n           = bus.inst_rd0[8 +: OPW];
  assign hdr_bound       = pc_q + 32'd1 + 32'(hdr_n);
  assign beat_cnt        = (rem_q >= OPW'(4)) ? 3'd4 : rem_q[2:0];
  assign unused_hdr_bits = ^bus.inst_rd0[30:8+OPW];

  assign win[0] = bus.inst_rd1;
  assign win[1] = bus.inst_rd2;
  assign win[2] = bus.inst_rd3;
  assign win[3] = bus.inst_rd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    opc_d   = opc_q;
    imm_d   = imm_q;
    nops_d  = nops_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = base_addr;
          err_d   = 1'b0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (pc_q >= end_addr) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (hdr_ext && (hdr_bound > end_addr)) begin
          // Operands would run past the list end: abort before anything is emitted.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          opc_d   = bus.inst_rd0[OPW-1:0];
          imm_d   = hdr_ext ? '0 : hdr_n;
          nops_d  = hdr_ext ? hdr_n : '0;
          rem_d   = hdr_ext ? hdr_n : '0;
          pc_d    = pc_q + 32'd1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.cmd_ready) state_d = (rem_q == '0) ? S_HDR : S_OPS_F;
      end
      S_OPS_F: begin
        // Lanes past the remaining count are zeroed so stale or undefined
        // window words never leak into the beat.
        for (int k = 0; k < 4; k++) begin
          data_d[k] = (3'(k) < beat_cnt) ? win[k] : '0;
        end
        cnt_d   = beat_cnt;
        last_d  = (rem_q <= OPW'(4));
        pc_d    = pc_q + 32'(beat_cnt);
        rem_d   = rem_q - OPW'(beat_cnt);
        state_d = S_OPS_S;
      end
      S_OPS_S: begin
        if (bus.op_ready) state_d = last_q ? S_HDR : S_OPS_F;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      opc_q   <= '0;
      imm_q   <= '0;
      nops_q  <= '0;
      data_q  <= '{default: '0};
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
      opc_q   <= opc_d;
      imm_q   <= imm_d;
      nops_q  <= nops_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign bus.inst_addr1 = (state_q == S_HDR) ? pc_q : '0;
  assign bus.inst_addr2 = (state_q == S_OPS_F) ? pc_q : '0;
  assign bus.cmd_valid  = (state_q == S_CMD);
  assign bus.cmd_opcode = opc_q;
  assign bus.cmd_imm    = imm_q;
  assign bus.cmd_nops   = nops_q;
  assign bus.op_valid   = (state_q == S_OPS_S);
  assign bus.op_data0   = data_q[0];
  assign bus.op_data1   = data_q[1];
  assign bus.op_data2   = data_q[2];
  assign bus.op_data3   = data_q[3];
  assign bus.op_cnt     = cnt_q;
  assign bus.op_last    = last_q;

  a_list_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_IDLE && start) |->
      (base_addr <= 32'(MEM_DEPTH) && end_addr <= 32'(MEM_DEPTH)));

endmodule

// File: tb/tb_inst_cmd_fetch.sv
// Scoreboard bench for inst_cmd_fetch: a behavioural memory walker predicts the
// header/beat stream, a negedge monitor pops and compares every transfer.
module tb_inst_cmd_fetch;
  localparam int MEM_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] end_addr = '0;
  logic        busy, done, err;

  inst_cmd_fetch_if #(.OPW(8)) bus_if ();

  inst_cmd_fetch #(.MEM_DEPTH(MEM_DEPTH), .OPW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .end_addr  (end_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:MEM_DEPTH-1];
  logic [31:0] wa1, wa2, wa3, wa4;
  assign wa1 = bus_if.inst_addr2;
  assign wa2 = bus_if.inst_addr2 + 32'd1;
  assign wa3 = bus_if.inst_addr2 + 32'd2;
  assign wa4 = bus_if.inst_addr2 + 32'd3;
  assign bus_if.inst_rd0 = (bus_if.inst_addr1 < MEM_DEPTH) ? mem[bus_if.inst_addr1[5:0]] : 32'hDEAD_BEEF;
  assign bus_if.inst_rd1 = (wa1 < MEM_DEPTH) ? mem[wa1[5:0]] : 32'hDEAD_BEEF;
  assign bus_if.inst_rd2 = (wa2 < MEM_DEPTH) ? mem[wa2[5:0]] : 32'hDEAD_BEEF;
  assign bus_if.inst_rd3 = (wa3 < MEM_DEPTH) ? mem[wa3[5:0]] : 32'hDEAD_BEEF;
  assign bus_if.inst_rd4 = (wa4 < MEM_DEPTH) ? mem[wa4[5:0]] : 32'hDEAD_BEEF;

  logic [224:0] all_outs;
  assign all_outs = {busy, done, err, bus_if.inst_addr1, bus_if.inst_addr2,
                     bus_if.cmd_valid, bus_if.cmd_opcode, bus_if.cmd_imm, bus_if.cmd_nops,
                     bus_if.op_valid, bus_if.op_data0, bus_if.op_data1, bus_if.op_data2,
                     bus_if.op_data3, bus_if.op_cnt, bus_if.op_last};

  typedef struct packed {
    logic        is_cmd;
    logic [7:0]  opc;
    logic [7:0]  imm;
    logic [7:0]  nops;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic [2:0]  cnt;
    logic        last;
  } item_t;

  item_t exp_q[$];
  item_t log_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    hdr_cnt = 0;
  int    beat_cnt = 0;
  bit    m_done, m_err;
  bit    bp = 1'b0;

  function automatic item_t mk_cmd(input logic [7:0] o, input logic [7:0] i, input logic [7:0] n);
    item_t t;
    t = '0;
    t.is_cmd = 1'b1;
    t.opc = o;
    t.imm = i;
    t.nops = n;
    return t;
  endfunction

  function automatic item_t mk_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                    input logic [31:0] d, input logic [2:0] k, input logic l);
    item_t t;
    t = '0;
    t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d;
    t.cnt = k;
    t.last = l;
    return t;
  endfunction

  task automatic init_mem();
    logic [31:0] prog [0:41];
    prog = '{32'h00000110, 32'h80001011,
             32'h3B4CCCCD, 32'h0, 32'h0, 32'h0,
             32'h0, 32'h3B4CCCCD, 32'h0, 32'h0,
             32'h0, 32'h0, 32'h3B4CCCCD, 32'h0,
             32'hBF000000, 32'hBF000000, 32'hC0000000, 32'h3F800000,
             32'h80000304, 32'h3F800000, 32'h0, 32'h0,
             32'h80000303, 32'hBF000000, 32'hBF000000, 32'h0,
             32'h80000304, 32'h0, 32'h3F800000, 32'h0,
             32'h80000303, 32'h3F000000, 32'hBF000000, 32'h0,
             32'h80000304, 32'h0, 32'h0, 32'h3F800000,
             32'h80000303, 32'h0, 32'h3F000000, 32'h0};
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = (i < 42) ? prog[i] : (32'hA5A50000 | 32'(i));
  endtask

  // Independent walk of the command list straight from the memory contents.
  task automatic model(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] pc, w;
    int          rem, n, c;
    item_t       it;
    m_done = 1'b0;
    m_err  = 1'b0;
    pc     = b;
    for (int guard = 0; guard < 200; guard++) begin
      if (pc >= e) begin m_done = 1'b1; break; end
      w = mem[pc[5:0]];
      n = int'(w[15:8]);
      if (w[31] && (pc + 32'd1 + 32'(n)) > e) begin m_err = 1'b1; break; end
      it = w[31] ? mk_cmd(w[7:0], 8'h00, w[15:8]) : mk_cmd(w[7:0], w[15:8], 8'h00);
      exp_q.push_back(it);
      pc  = pc + 32'd1;
      rem = w[31] ? n : 0;
      while (rem > 0) begin
        c  = (rem > 4) ? 4 : rem;
        it = mk_beat(mem[pc[5:0]],
                     (c > 1) ? mem[6'(pc + 32'd1)] : 32'h0,
                     (c > 2) ? mem[6'(pc + 32'd2)] : 32'h0,
                     (c > 3) ? mem[6'(pc + 32'd3)] : 32'h0,
                     3'(c), rem <= 4);
        exp_q.push_back(it);
        pc  = pc + 32'(c);
        rem = rem - c;
      end
    end
  endtask

  // Ready drivers: always-ready, or held low 3 cycles on every offered item.
  initial begin
    int cw, ow;
    cw = 0;
    ow = 0;
    bus_if.cmd_ready = 1'b1;
    bus_if.op_ready  = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!bp) begin
        bus_if.cmd_ready = 1'b1; bus_if.op_ready = 1'b1; cw = 0; ow = 0;
      end else begin
        if (!bus_if.cmd_valid) begin bus_if.cmd_ready = 1'b0; cw = 0; end
        else if (cw < 3) begin bus_if.cmd_ready = 1'b0; cw++; end
        else bus_if.cmd_ready = 1'b1;
        if (!bus_if.op_valid) begin bus_if.op_ready = 1'b0; ow = 0; end
        else if (ow < 3) begin bus_if.op_ready = 1'b0; ow++; end
        else bus_if.op_ready = 1'b1;
      end
    end
  end

  item_t held, cur, want;
  bit    held_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (bus_if.cmd_valid && bus_if.op_valid) begin
        checks++; errors++;
        $display("FAIL excl: cmd_valid and op_valid both 1, required at most one");
      end
      if (bus_if.cmd_valid || bus_if.op_valid) begin
        if (bus_if.cmd_valid) cur = mk_cmd(bus_if.cmd_opcode, bus_if.cmd_imm, bus_if.cmd_nops);
        else cur = mk_beat(bus_if.op_data0, bus_if.op_data1, bus_if.op_data2, bus_if.op_data3,
                           bus_if.op_cnt, bus_if.op_last);
        if (held_v) begin
          checks++;
          if (cur !== held) begin
            errors++;
            $display("FAIL hold: item %h changed, required %h", cur, held);
          end
        end
        if ((bus_if.cmd_valid && bus_if.cmd_ready) || (bus_if.op_valid && bus_if.op_ready)) begin
          if (cur.is_cmd) hdr_cnt++; else beat_cnt++;
          log_q.push_back(cur);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream: unexpected item %h, required none", cur);
          end else begin
            want = exp_q.pop_front();
            if (cur !== want) begin
              errors++;
              $display("FAIL stream: got %h required %h", cur, want);
            end
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end else begin
        if (held_v) begin
          checks++; errors++;
          $display("FAIL hold: valid dropped before accept, required held item %h", held);
        end
        held_v = 1'b0;
      end
    end
  end

  task automatic start_run(input logic [31:0] b, input logic [31:0] e);
    model(b, e);
    base_addr = b;
    end_addr  = e;
    done_cnt  = 0;
    hdr_cnt   = 0;
    beat_cnt  = 0;
    log_q.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b required 0", name, busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d items undelivered, required 0", name, exp_q.size());
    end
    exp_q.delete();
    checks++;
    if (done_cnt != (m_done ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d required %0d", name, done_cnt, m_done ? 1 : 0);
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL %s_err: err=%0b required %0b", name, err, m_err);
    end
  endtask

  task automatic check_counts(input string name, input int h, input int bt);
    checks++;
    if (hdr_cnt != h || beat_cnt != bt) begin
      errors++;
      $display("FAIL %s_counts: headers=%0d beats=%0d required %0d %0d", name, hdr_cnt, beat_cnt, h, bt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %h required 0", all_outs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_reference();
    int    idx [7];
    item_t ref_item [7];
    bp = 1'b0;
    start_run(32'd0, 32'd42);
    wait_idle("ref");
    check_end("ref");
    check_counts("ref", 8, 10);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ref_done_once: pulses=%0d required 1", done_cnt);
    end
    idx = '{0, 1, 2, 5, 6, 7, 8};
    ref_item[0] = mk_cmd(8'h10, 8'h01, 8'h00);
    ref_item[1] = mk_cmd(8'h11, 8'h00, 8'h10);
    ref_item[2] = mk_beat(32'h3B4CCCCD, 32'h0, 32'h0, 32'h0, 3'd4, 1'b0);
    ref_item[3] = mk_beat(32'hBF000000, 32'hBF000000, 32'hC0000000, 32'h3F800000, 3'd4, 1'b1);
    ref_item[4] = mk_cmd(8'h04, 8'h00, 8'h03);
    ref_item[5] = mk_beat(32'h3F800000, 32'h0, 32'h0, 32'h0, 3'd3, 1'b1);
    ref_item[6] = mk_cmd(8'h03, 8'h00, 8'h03);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (log_q.size() <= idx[i]) begin
        errors++;
        $display("FAIL ref_item%0d: stream too short (%0d), required item %h", idx[i], log_q.size(), ref_item[i]);
      end else if (log_q[idx[i]] !== ref_item[i]) begin
        errors++;
        $display("FAIL ref_item%0d: got %h required %h", idx[i], log_q[idx[i]], ref_item[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bp = 1'b1;
    start_run(32'd0, 32'd42);
    wait_idle("bp");
    check_end("bp");
    check_counts("bp", 8, 10);
    bp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    start_run(32'd0, 32'd20);
    wait_idle("ovr");
    check_end("ovr");
    check_counts("ovr", 2, 4);
    checks++;
    if (err !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL ovr_flags: err=%0b done_pulses=%0d required 1 0", err, done_cnt);
    end
  endtask

  task automatic test_start_busy();
    start_run(32'd0, 32'd42);
    repeat (10) @(posedge clk);
    #1;
    base_addr = 32'd18;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 32'd0;
    wait_idle("sbusy");
    check_end("sbusy");
    check_counts("sbusy", 8, 10);
  endtask

  task automatic test_empty();
    model(32'd5, 32'd5);
    base_addr = 32'd5;
    end_addr  = 32'd5;
    done_cnt  = 0;
    hdr_cnt   = 0;
    beat_cnt  = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_c1: done=%0b busy=%0b required 0 1", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bus_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_c2: done=%0b busy=%0b cmd_valid=%0b required 1 0 0", done, busy, bus_if.cmd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL empty_c3: done=%0b required 0", done);
    end
    check_end("empty");
    check_counts("empty", 0, 0);
  endtask

  task automatic test_reset_midrun();
    int n;
    start_run(32'd0, 32'd42);
    n = 0;
    while (!(bus_if.op_valid && bus_if.cmd_opcode == 8'h11) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!(bus_if.op_valid && bus_if.cmd_opcode == 8'h11)) begin
      errors++;
      $display("FAIL rstmid_reach: op_valid=%0b opcode=%h required 1 11", bus_if.op_valid, bus_if.cmd_opcode);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL rstmid_outs: got %h required 0", all_outs);
    end
    rst_n = 1'b1;
    exp_q.delete();
    start_run(32'd0, 32'd42);
    wait_idle("rstmid");
    check_end("rstmid");
    check_counts("rstmid", 8, 10);
  endtask

  task automatic test_zero_ops();
    mem[0] = 32'h80000005;
    start_run(32'd0, 32'd1);
    wait_idle("zop");
    check_end("zop");
    check_counts("zop", 1, 0);
    checks++;
    if (log_q.size() != 1 || log_q[0] !== mk_cmd(8'h05, 8'h00, 8'h00)) begin
      errors++;
      $display("FAIL zop_hdr: items=%0d first=%h required 1 %h", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : item_t'('0), mk_cmd(8'h05, 8'h00, 8'h00));
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_reference();
    test_backpressure();
    test_overrun();
    test_start_busy();
    test_empty();
    test_reset_midrun();
    test_zero_ops();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
